cv32e40p_rf_load_tracker: RTL and testbench

Tracks destination registers of outstanding LSU loads between issue and write-back, and drives write port B of the register file when load data returns. Sits between the LSU response path and the latch register file's W2 port. Flags read-after-write hazards on the three read ports so the ID stage can stall operands whose load has not yet been written.

---
 rtl/cv32e40p_rf_load_tracker_if.sv | 58 +++++
 rtl/cv32e40p_rf_load_tracker.sv | 136 +++++++++++++
 tb/tb_cv32e40p_rf_load_tracker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cv32e40p_rf_load_tracker_if.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_rf_load_tracker_if
// Description : Bundle of the load tracker signals: the issue handshake, the
//               LSU response, flush, write port B of the register file, the
//               three read-address hazard probes and the status outputs.
//               The slave modport is the tracker; the master modport is the
//               surrounding pipeline (ID/LSU side).
// Parameters  : ADDR_WIDTH - register address width
//               DATA_WIDTH - load data width
//               DEPTH      - maximum outstanding loads (1, 2 or 4)
// Revision    : 1.0 - initial release
// ============================================================================
interface cv32e40p_rf_load_tracker_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    // Issue side
    logic                  issue_valid_i;
    logic                  issue_ready_o;
    logic [ADDR_WIDTH-1:0] issue_waddr_i;
    // LSU response
    logic                  lsu_rvalid_i;
    logic [DATA_WIDTH-1:0] lsu_rdata_i;
    logic                  flush_i;
    // Register file write port B
    logic                  we_b_o;
    logic [ADDR_WIDTH-1:0] waddr_b_o;
    logic [DATA_WIDTH-1:0] wdata_b_o;
    // Hazard probes
    logic [ADDR_WIDTH-1:0] raddr_a_i;
    logic [ADDR_WIDTH-1:0] raddr_b_i;
    logic [ADDR_WIDTH-1:0] raddr_c_i;
    logic                  hazard_a_o;
    logic                  hazard_b_o;
    logic                  hazard_c_o;
    // Status
    logic [c_CNT_W-1:0]    outstanding_o;
    logic                  err_o;

    modport master (
        output issue_valid_i, issue_waddr_i, lsu_rvalid_i, lsu_rdata_i, flush_i,
               raddr_a_i, raddr_b_i, raddr_c_i,
        input  issue_ready_o, we_b_o, waddr_b_o, wdata_b_o,
               hazard_a_o, hazard_b_o, hazard_c_o, outstanding_o, err_o
    );

    modport slave (
        input  issue_valid_i, issue_waddr_i, lsu_rvalid_i, lsu_rdata_i, flush_i,
               raddr_a_i, raddr_b_i, raddr_c_i,
        output issue_ready_o, we_b_o, waddr_b_o, wdata_b_o,
               hazard_a_o, hazard_b_o, hazard_c_o, outstanding_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/cv32e40p_rf_load_tracker.sv
`default_nettype none
// ============================================================================
// Module      : cv32e40p_rf_load_tracker
// Description : Tracks destination registers of outstanding LSU loads in a
//               small FIFO, drives register file write port B when load data
//               returns, and flags read-after-write hazards on three read
//               ports.
// Ports       : clk_int - gated core clock
//               rst_n   - asynchronous active-low reset
//               bus     - cv32e40p_rf_load_tracker_if.slave (issue, response,
//                         flush, write port B, hazard probes, status)
// Options     : CV32E40P_RF_LOAD_BYPASS_EN - when defined, the head entry
//               being popped this cycle does not raise a hazard, so ID can
//               take the operand straight from wdata_b_o.
// Revision    : 1.0 - initial release
// ============================================================================
module cv32e40p_rf_load_tracker #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                           clk_int,
    input  logic                           rst_n,
    cv32e40p_rf_load_tracker_if.slave      bus
);

    localparam int                 c_CNT_W     = $clog2(DEPTH + 1);
    localparam int                 c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(DEPTH - 1);

    // FIFO state
    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH-1:0] r_waddr [DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_head_waddr;
    logic [DEPTH-1:0]      w_live;
    logic [DEPTH-1:0]      w_match_a;
    logic [DEPTH-1:0]      w_match_b;
    logic [DEPTH-1:0]      w_match_c;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_full       = (r_count == c_DEPTH_CNT);
    assign w_empty      = (r_count == '0);
    // Full blocks issue even when a pop frees a slot this same cycle.
    assign w_push       = bus.issue_valid_i && !w_full;
    assign w_pop        = bus.lsu_rvalid_i && !w_empty;
    assign w_head_waddr = r_waddr[r_rptr];

    // Write port B: purely combinational from the response and the head entry.
    assign bus.issue_ready_o = !w_full;
    assign bus.we_b_o        = w_pop && (w_head_waddr != '0);
    assign bus.waddr_b_o     = w_head_waddr;
    assign bus.wdata_b_o     = bus.lsu_rdata_i;
    assign bus.outstanding_o = r_count;
    assign bus.err_o         = r_err;

    // Entries that may raise a hazard. Without bypass this is registered
    // state only; with bypass the head being popped right now is masked.
    always_comb begin
        w_live    = r_valid;
        w_match_a = '0;
        w_match_b = '0;
        w_match_c = '0;
`ifdef CV32E40P_RF_LOAD_BYPASS_EN
        if (w_pop) begin
            w_live[r_rptr] = 1'b0;
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            w_match_a[i] = (r_waddr[i] == bus.raddr_a_i);
            w_match_b[i] = (r_waddr[i] == bus.raddr_b_i);
            w_match_c[i] = (r_waddr[i] == bus.raddr_c_i);
        end
    end

    // x0 is never a hazard even though loads to it are tracked.
    assign bus.hazard_a_o = (bus.raddr_a_i != '0) && |(w_live & w_match_a);
    assign bus.hazard_b_o = (bus.raddr_b_i != '0) && |(w_live & w_match_b);
    assign bus.hazard_c_o = (bus.raddr_c_i != '0) && |(w_live & w_match_c);

    always_ff @(posedge clk_int or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_waddr[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            // A response with nothing outstanding is a protocol error; sticky.
            if (bus.lsu_rvalid_i && w_empty) begin
                r_err <= 1'b1;
            end

            if (bus.flush_i) begin
                r_valid <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                // Push and pop never hit the same slot: pointers coincide only
                // when empty (no pop) or full (no push).
                if (w_pop) begin
                    r_valid[r_rptr] <= 1'b0;
                    r_rptr          <= ptr_next(r_rptr);
                end
                if (w_push) begin
                    r_valid[r_wptr] <= 1'b1;
                    r_waddr[r_wptr] <= bus.issue_waddr_i;
                    r_wptr          <= ptr_next(r_wptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_rf_load_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cv32e40p_rf_load_tracker
// Description : Self-checking bench for cv32e40p_rf_load_tracker. A queue of
//               pending destination registers serves as the reference model.
//               Directed scenarios are followed by an asynchronous reset
//               check and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_rf_load_tracker;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
`ifdef CV32E40P_RF_LOAD_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic clk_int = 1'b0;
    logic rst_n   = 1'b0;

    always #5 clk_int = ~clk_int;

    cv32e40p_rf_load_tracker_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
    ) u_if ();

    cv32e40p_rf_load_tracker #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
    ) u_dut (
        .clk_int (clk_int),
        .rst_n   (rst_n),
        .bus     (u_if)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pending load destinations in issue order, sticky error.
    int q[$];
    bit m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_haz(input int ra, input bit popping);
        int n = 0;
        if (ra == 0) return 1'b0;
        foreach (q[i]) if (q[i] == ra) n++;
        if (c_BYPASS && popping && q[0] == ra) n--;
        return n > 0;
    endfunction

    // One clock cycle: drive inputs, check all outputs mid-cycle against the
    // model, then advance the model across the clock edge.
    task automatic cycle(input bit iv, input int wa, input bit rv, input logic [31:0] rd,
                         input bit fl, input int ra, input int rb, input int rc);
        bit ready, pop, we;
        @(negedge clk_int);
        u_if.issue_valid_i = iv;
        u_if.issue_waddr_i = AW'(wa);
        u_if.lsu_rvalid_i  = rv;
        u_if.lsu_rdata_i   = rd;
        u_if.flush_i       = fl;
        u_if.raddr_a_i     = AW'(ra);
        u_if.raddr_b_i     = AW'(rb);
        u_if.raddr_c_i     = AW'(rc);
        #2;
        ready = (q.size() != DEPTH);
        pop   = rv && (q.size() != 0);
        we    = pop && (q[0] != 0);
        chk("issue_ready", u_if.issue_ready_o, ready);
        chk("we_b", u_if.we_b_o, we);
        if (pop) chk("waddr_b", u_if.waddr_b_o, q[0]);
        chk("wdata_b", u_if.wdata_b_o, rd);
        chk("hazard_a", u_if.hazard_a_o, exp_haz(ra, pop));
        chk("hazard_b", u_if.hazard_b_o, exp_haz(rb, pop));
        chk("hazard_c", u_if.hazard_c_o, exp_haz(rc, pop));
        chk("outstanding", u_if.outstanding_o, q.size());
        chk("err", u_if.err_o, m_err);
        @(posedge clk_int);
        if (rv && q.size() == 0) m_err = 1'b1;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (iv && ready) q.push_back(wa);
        end
    endtask

    initial begin
        u_if.issue_valid_i = 1'b0;
        u_if.issue_waddr_i = '0;
        u_if.lsu_rvalid_i  = 1'b0;
        u_if.lsu_rdata_i   = '0;
        u_if.flush_i       = 1'b0;
        u_if.raddr_a_i     = '0;
        u_if.raddr_b_i     = '0;
        u_if.raddr_c_i     = '0;
        m_err = 1'b0;
        repeat (2) @(posedge clk_int);
        @(negedge clk_int);
        rst_n = 1'b1;

        // Reset state
        cycle(0, 0, 0, 32'h0, 0, 5, 0, 0);

        // Basic issue / hazard / write-back of x5
        cycle(1, 5, 0, 32'h0, 0, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 5, 0, 0);
        cycle(0, 0, 1, 32'hDEADBEEF, 0, 5, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 5, 0, 0);

        // Fill to DEPTH, blocked issue, rvalid+issue while full
        cycle(1, 3, 0, 32'h0, 0, 3, 7, 0);
        cycle(1, 7, 0, 32'h0, 0, 3, 7, 0);
        cycle(1, 8, 0, 32'h0, 0, 3, 7, 8);
        cycle(1, 8, 1, 32'h11112222, 0, 3, 7, 8);
        cycle(0, 0, 0, 32'h0, 0, 3, 7, 8);
        cycle(0, 0, 1, 32'h33334444, 0, 7, 0, 0);

        // Two loads to x9
        cycle(1, 9, 0, 32'h0, 0, 9, 0, 0);
        cycle(1, 9, 0, 32'h0, 0, 9, 0, 0);
        cycle(0, 0, 1, 32'hA5A5A5A5, 0, 9, 9, 0);
        cycle(0, 0, 1, 32'h5A5A5A5A, 0, 9, 0, 9);
        cycle(0, 0, 0, 32'h0, 0, 9, 9, 9);

        // Load to x0: consumed, no write, no hazard
        cycle(1, 0, 0, 32'h0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0, 0);

        // Flush with two pending, then a stray response sets sticky err
        cycle(1, 4, 0, 32'h0, 0, 4, 6, 0);
        cycle(1, 6, 0, 32'h0, 0, 4, 6, 0);
        cycle(1, 2, 0, 32'h0, 1, 4, 6, 2);
        cycle(0, 0, 0, 32'h0, 0, 4, 6, 2);
        cycle(0, 0, 1, 32'h12345678, 0, 4, 6, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0, 0);
        cycle(0, 0, 0, 32'h0, 0, 0, 0, 0);

        // Asynchronous reset with two entries pending
        cycle(1, 4, 0, 32'h0, 0, 0, 0, 0);
        cycle(1, 6, 0, 32'h0, 0, 0, 0, 0);
        @(negedge clk_int);
        u_if.issue_valid_i = 1'b0;
        u_if.lsu_rvalid_i  = 1'b1;
        u_if.raddr_a_i     = AW'(4);
        u_if.raddr_b_i     = AW'(6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", u_if.issue_ready_o, 1'b1);
        chk("rst_we_b", u_if.we_b_o, 1'b0);
        chk("rst_waddr_b", u_if.waddr_b_o, 0);
        chk("rst_hazard_a", u_if.hazard_a_o, 1'b0);
        chk("rst_hazard_b", u_if.hazard_b_o, 1'b0);
        chk("rst_outstanding", u_if.outstanding_o, 0);
        chk("rst_err", u_if.err_o, 1'b0);
        q.delete();
        m_err = 1'b0;
        u_if.lsu_rvalid_i = 1'b0;
        @(posedge clk_int);
        @(negedge clk_int);
        rst_n = 1'b1;

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 32'($urandom),
                  ($urandom_range(0, 19) == 0),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
